ptw_arbiter: RTL and testbench
==============================

# ptw_arbiter

Two-requester arbiter that shares one page-table walker (PTW) port between the instruction TLB (requester 0) and the data TLB (requester 1). It accepts one TLB miss at a time, latches the miss request, presents it to the walker and steers the walker response back to the owning TLB. It sits between the TLB `io_ptw_*` ports and the walker, and holds exactly one walk in flight.

## Interface
- ADDR_W, 27: VPN width of `io_ptw_req_bits_addr`.
- PPN_W, 38: PTE PPN width forwarded to both TLBs.

- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- io_reqN_valid  in  1  TLB N miss request valid (N = 0 ITLB, 1 DTLB).
- io_reqN_ready  out  1  request accepted this cycle.
- io_reqN_bits_addr  in  ADDR_W  VPN.
- io_reqN_bits_prv  in  2  privilege.
- io_reqN_bits_{pum,mxr,store,fetch}  in  1 each  request attributes.
- io_respN_valid  out  1  walker response belongs to TLB N.
- io_resp_bits_pte_ppn  out  PPN_W  PTE PPN, shared by both TLBs.
- io_resp_bits_pte_{d,a,g,u,x,w,r,v}  out  1 each  PTE flags, shared by both TLBs.
- io_invalidate  in  1  SFENCE/ASID change from the CSR file.
- io_reqN_invalidate  out  1  `io_invalidate` fanned out to both TLBs.
- io_ptw_req_valid  out  1  request to walker.
- io_ptw_req_ready  in  1  walker accepts.
- io_ptw_req_bits_{addr,prv,pum,mxr,store,fetch}  out  as above  latched request.
- io_ptw_resp_valid  in  1  walker response.
- io_ptw_resp_bits_pte_ppn / _{d,a,g,u,x,w,r,v}  in  PPN_W / 1  walker PTE.
- io_owner  out  1  index of the current owner; 0 in S_idle.

## Operation
- States: S_idle=2'h0, S_req=2'h1, S_wait=2'h2.
- S_idle:
  - If any `io_reqN_valid` is high, pick the winner (see Configuration) and drive `io_reqN_ready`=1 for the winner only, combinationally, in the same cycle.
  - Latch the winner's addr, prv, pum, mxr, store and fetch, plus the owner index.
  - Next state is S_req.
  - The loser sees ready=0 and keeps its valid asserted.
- S_req:
  - `io_ptw_req_valid`=1, driven with the latched bits.
  - On `io_ptw_req_ready`=1, next state is S_wait.
  - `io_reqN_ready`=0 for both requesters.
- S_wait:
  - On `io_ptw_resp_valid`=1, drive `io_resp<owner>_valid`=1 in the same cycle (combinational); the other requester's resp_valid stays 0.
  - Next state is S_idle.
- PTE bits pass combinationally from walker to both TLBs in every state; only the valid is steered.
- `io_invalidate`:
  - Forwarded combinationally to both TLBs.
  - Does not abort S_req or S_wait. A TLB that has been accepted always waits for its response, so the arbiter must complete the walk.
- `io_ptw_resp_valid` in S_idle or S_req is ignored: it reaches no requester and causes no state change.
- Reset: state is S_idle, owner 0, RR pointer 0, latched bits 0. Every output is 0 except the combinational pass-through PTE/invalidate outputs, which follow their inputs.

## Timing
- Acceptance to walker request: 1 cycle. Accepted at edge T, `io_ptw_req_valid` is high from T+1.
- Walker response to TLB: 0 cycles.
- Earliest next acceptance: the cycle after the response. Back-to-back minimum is accept, S_req, S_wait+resp, accept again, i.e. 3 cycles per walk with an always-ready, 1-cycle walker.
- `io_ptw_req_ready` and `io_ptw_resp_valid` in the same cycle during S_req: take the request only, go to S_wait, and ignore the response.
- Reset asserted mid-walk: next state is S_idle and the in-flight walk is dropped. The walker is reset by the same signal.

## Configuration
- PTW_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer `last` records the most recent grant.
  - When both requesters are valid in S_idle, grant `!last`.
  - When only one is valid, grant that one.
  - `last` updates on every grant.
- PTW_ARB_RR_EN undefined: fixed priority, ITLB (requester 0) always wins a tie. No pointer register exists.

## Test plan
- ITLB-only miss, walker ready, response 2 cycles after acceptance (addr=27'h0123456, pte_ppn=38'h00000ABCDE) -> `io_req0_ready`=1 for one cycle, `io_ptw_req_bits_addr`=27'h0123456 next cycle, `io_resp0_valid`=1 with PPN 20'hABCDE, `io_resp1_valid`=0.
- Both valid in S_idle, three consecutive walks -> with RR_EN the grants run 0,1,0; without it they run 0,0,0 and the DTLB starves while the ITLB stays valid.
- Walker holds `io_ptw_req_ready`=0 for 5 cycles -> `io_ptw_req_valid` stays 1 with stable bits, both `io_reqN_ready`=0, state stays S_req.
- `io_invalidate` pulsed in S_req and again in S_wait -> both `io_reqN_invalidate` pulse, the walk completes, and the response is steered to the owner.
- Spurious `io_ptw_resp_valid` in S_idle, then reset asserted in S_wait -> no resp_valid raised; after reset all outputs are 0 and state is S_idle.

Source files
------------

// File: rtl/ptw_arbiter.sv
// Shares one page-table walker between the ITLB (0) and DTLB (1), one walk in flight.
// PTW_ARB_RR_EN selects round-robin arbitration; fixed ITLB priority otherwise.
module ptw_arbiter #(
  parameter int ADDR_W = 27,
  parameter int PPN_W  = 38
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req0_valid,
  output logic              io_req0_ready,
  input  logic [ADDR_W-1:0] io_req0_bits_addr,
  input  logic [1:0]        io_req0_bits_prv,
  input  logic              io_req0_bits_pum,
  input  logic              io_req0_bits_mxr,
  input  logic              io_req0_bits_store,
  input  logic              io_req0_bits_fetch,
  input  logic              io_req1_valid,
  output logic              io_req1_ready,
  input  logic [ADDR_W-1:0] io_req1_bits_addr,
  input  logic [1:0]        io_req1_bits_prv,
  input  logic              io_req1_bits_pum,
  input  logic              io_req1_bits_mxr,
  input  logic              io_req1_bits_store,
  input  logic              io_req1_bits_fetch,
  output logic              io_resp0_valid,
  output logic              io_resp1_valid,
  output logic [PPN_W-1:0]  io_resp_bits_pte_ppn,
  output logic              io_resp_bits_pte_d,
  output logic              io_resp_bits_pte_a,
  output logic              io_resp_bits_pte_g,
  output logic              io_resp_bits_pte_u,
  output logic              io_resp_bits_pte_x,
  output logic              io_resp_bits_pte_w,
  output logic              io_resp_bits_pte_r,
  output logic              io_resp_bits_pte_v,
  input  logic              io_invalidate,
  output logic              io_req0_invalidate,
  output logic              io_req1_invalidate,
  output logic              io_ptw_req_valid,
  input  logic              io_ptw_req_ready,
  output logic [ADDR_W-1:0] io_ptw_req_bits_addr,
  output logic [1:0]        io_ptw_req_bits_prv,
  output logic              io_ptw_req_bits_pum,
  output logic              io_ptw_req_bits_mxr,
  output logic              io_ptw_req_bits_store,
  output logic              io_ptw_req_bits_fetch,
  input  logic              io_ptw_resp_valid,
  input  logic [PPN_W-1:0]  io_ptw_resp_bits_pte_ppn,
  input  logic              io_ptw_resp_bits_pte_d,
  input  logic              io_ptw_resp_bits_pte_a,
  input  logic              io_ptw_resp_bits_pte_g,
  input  logic              io_ptw_resp_bits_pte_u,
  input  logic              io_ptw_resp_bits_pte_x,
  input  logic              io_ptw_resp_bits_pte_w,
  input  logic              io_ptw_resp_bits_pte_r,
  input  logic              io_ptw_resp_bits_pte_v,
  output logic              io_owner
);

  typedef enum logic [1:0] {
    S_idle = 2'h0,
    S_req  = 2'h1,
    S_wait = 2'h2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        prv_q, prv_d;
  logic [3:0]        attr_q, attr_d;
  logic [1:0]        grant;
  logic              any_v;
  logic              win;
`ifdef PTW_ARB_RR_EN
  logic              last_q, last_d;
`endif

  assign any_v = io_req0_valid | io_req1_valid;

`ifdef PTW_ARB_RR_EN
  // On a tie the requester not granted last time wins.
  assign win = (io_req0_valid & io_req1_valid) ? ~last_q : io_req1_valid;
`else
  assign win = ~io_req0_valid;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    prv_d   = prv_q;
    attr_d  = attr_q;
    grant   = 2'b00;
`ifdef PTW_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      S_idle: begin
        if (any_v) begin
          grant   = win ? 2'b10 : 2'b01;
          owner_d = win;
          state_d = S_req;
`ifdef PTW_ARB_RR_EN
          last_d  = win;
`endif
          if (win) begin
            addr_d = io_req1_bits_addr;
            prv_d  = io_req1_bits_prv;
            attr_d = {io_req1_bits_pum, io_req1_bits_mxr,
                      io_req1_bits_store, io_req1_bits_fetch};
          end else begin
            addr_d = io_req0_bits_addr;
            prv_d  = io_req0_bits_prv;
            attr_d = {io_req0_bits_pum, io_req0_bits_mxr,
                      io_req0_bits_store, io_req0_bits_fetch};
          end
        end
      end
      S_req: begin
        if (io_ptw_req_ready) state_d = S_wait;
      end
      S_wait: begin
        if (io_ptw_resp_valid) state_d = S_idle;
      end
      default: state_d = S_idle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_idle;
      owner_q <= 1'b0;
      addr_q  <= '0;
      prv_q   <= '0;
      attr_q  <= '0;
`ifdef PTW_ARB_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      prv_q   <= prv_d;
      attr_q  <= attr_d;
`ifdef PTW_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign io_req0_ready = grant[0];
  assign io_req1_ready = grant[1];

  assign io_resp0_valid = (state_q == S_wait) & io_ptw_resp_valid & ~owner_q;
  assign io_resp1_valid = (state_q == S_wait) & io_ptw_resp_valid & owner_q;

  assign io_ptw_req_valid      = (state_q == S_req);
  assign io_ptw_req_bits_addr  = addr_q;
  assign io_ptw_req_bits_prv   = prv_q;
  assign io_ptw_req_bits_pum   = attr_q[3];
  assign io_ptw_req_bits_mxr   = attr_q[2];
  assign io_ptw_req_bits_store = attr_q[1];
  assign io_ptw_req_bits_fetch = attr_q[0];

  assign io_owner = (state_q == S_idle) ? 1'b0 : owner_q;

  assign io_req0_invalidate = io_invalidate;
  assign io_req1_invalidate = io_invalidate;

  assign io_resp_bits_pte_ppn = io_ptw_resp_bits_pte_ppn;
  assign io_resp_bits_pte_d   = io_ptw_resp_bits_pte_d;
  assign io_resp_bits_pte_a   = io_ptw_resp_bits_pte_a;
  assign io_resp_bits_pte_g   = io_ptw_resp_bits_pte_g;
  assign io_resp_bits_pte_u   = io_ptw_resp_bits_pte_u;
  assign io_resp_bits_pte_x   = io_ptw_resp_bits_pte_x;
  assign io_resp_bits_pte_w   = io_ptw_resp_bits_pte_w;
  assign io_resp_bits_pte_r   = io_ptw_resp_bits_pte_r;
  assign io_resp_bits_pte_v   = io_ptw_resp_bits_pte_v;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Bench for ptw_arbiter: directed vector table, corner sequences, random vs model.
// Define PTW_ARB_RR_EN for both bench and design to check round-robin mode.
module tb_ptw_arbiter;

  localparam logic [26:0] A0 = 27'h0123456;
  localparam logic [26:0] A1 = 27'h7654321;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  rv;
  logic [26:0] raddr [2];
  logic [1:0]  rprv [2];
  logic [3:0]  rattr [2];
  logic        inv;
  logic        ptw_rdy;
  logic        rsp_v;
  logic [37:0] pte_ppn;
  logic [7:0]  pte_f;

  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [37:0] o_ppn;
  logic [7:0]  o_f;
  logic        inv0, inv1, preq_v, owner;
  logic [26:0] p_addr;
  logic [1:0]  p_prv;
  logic [3:0]  p_attr;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ptw_arbiter dut (
    .clock                    (clock),
    .reset                    (reset),
    .io_req0_valid            (rv[0]),
    .io_req0_ready            (req0_ready),
    .io_req0_bits_addr        (raddr[0]),
    .io_req0_bits_prv         (rprv[0]),
    .io_req0_bits_pum         (rattr[0][3]),
    .io_req0_bits_mxr         (rattr[0][2]),
    .io_req0_bits_store       (rattr[0][1]),
    .io_req0_bits_fetch       (rattr[0][0]),
    .io_req1_valid            (rv[1]),
    .io_req1_ready            (req1_ready),
    .io_req1_bits_addr        (raddr[1]),
    .io_req1_bits_prv         (rprv[1]),
    .io_req1_bits_pum         (rattr[1][3]),
    .io_req1_bits_mxr         (rattr[1][2]),
    .io_req1_bits_store       (rattr[1][1]),
    .io_req1_bits_fetch       (rattr[1][0]),
    .io_resp0_valid           (resp0_valid),
    .io_resp1_valid           (resp1_valid),
    .io_resp_bits_pte_ppn     (o_ppn),
    .io_resp_bits_pte_d       (o_f[7]),
    .io_resp_bits_pte_a       (o_f[6]),
    .io_resp_bits_pte_g       (o_f[5]),
    .io_resp_bits_pte_u       (o_f[4]),
    .io_resp_bits_pte_x       (o_f[3]),
    .io_resp_bits_pte_w       (o_f[2]),
    .io_resp_bits_pte_r       (o_f[1]),
    .io_resp_bits_pte_v       (o_f[0]),
    .io_invalidate            (inv),
    .io_req0_invalidate       (inv0),
    .io_req1_invalidate       (inv1),
    .io_ptw_req_valid         (preq_v),
    .io_ptw_req_ready         (ptw_rdy),
    .io_ptw_req_bits_addr     (p_addr),
    .io_ptw_req_bits_prv      (p_prv),
    .io_ptw_req_bits_pum      (p_attr[3]),
    .io_ptw_req_bits_mxr      (p_attr[2]),
    .io_ptw_req_bits_store    (p_attr[1]),
    .io_ptw_req_bits_fetch    (p_attr[0]),
    .io_ptw_resp_valid        (rsp_v),
    .io_ptw_resp_bits_pte_ppn (pte_ppn),
    .io_ptw_resp_bits_pte_d   (pte_f[7]),
    .io_ptw_resp_bits_pte_a   (pte_f[6]),
    .io_ptw_resp_bits_pte_g   (pte_f[5]),
    .io_ptw_resp_bits_pte_u   (pte_f[4]),
    .io_ptw_resp_bits_pte_x   (pte_f[3]),
    .io_ptw_resp_bits_pte_w   (pte_f[2]),
    .io_ptw_resp_bits_pte_r   (pte_f[1]),
    .io_ptw_resp_bits_pte_v   (pte_f[0]),
    .io_owner                 (owner)
  );

  typedef struct {
    logic [1:0]  v;
    logic        prdy;
    logic        rspv;
    logic        inv;
    logic [1:0]  erdy;
    logic [1:0]  ersp;
    logic        epreq;
    logic        eown;
    logic [26:0] eaddr;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic [1:0] v, logic p, logic s, logic i,
                              logic [1:0] er, logic [1:0] es,
                              logic ep, logic eo, logic [26:0] ea);
    vec_t t;
    t.v = v; t.prdy = p; t.rspv = s; t.inv = i;
    t.erdy = er; t.ersp = es; t.epreq = ep; t.eown = eo; t.eaddr = ea;
    return t;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic step(input string tag, input logic [1:0] v,
                      input logic p, input logic s, input logic i,
                      input logic [1:0] er, input logic [1:0] es,
                      input logic ep, input logic eo, input logic [26:0] ea);
    @(negedge clock);
    rv = v; ptw_rdy = p; rsp_v = s; inv = i;
    #1;
    cmp({tag, ".ready"}, 64'({req1_ready, req0_ready}), 64'(er));
    cmp({tag, ".resp"}, 64'({resp1_valid, resp0_valid}), 64'(es));
    cmp({tag, ".preq"}, 64'(preq_v), 64'(ep));
    cmp({tag, ".owner"}, 64'(owner), 64'(eo));
    cmp({tag, ".inval"}, 64'({inv1, inv0}), 64'({i, i}));
    cmp({tag, ".ppn"}, 64'(o_ppn), 64'(pte_ppn));
    if (ep) cmp({tag, ".addr"}, 64'(p_addr), 64'(ea));
  endtask

  // Reference model state: walk phase 0 idle, 1 waiting walker accept, 2 waiting response
  int          mst;
  bit          mown, mlast, mwin;
  logic [26:0] maddr;
  logic [1:0]  mprv;
  logic [3:0]  mattr;

  initial begin
    logic g;
    logic [1:0] eg;
    reset = 1'b1;
    rv = 2'b00; inv = 1'b0; ptw_rdy = 1'b0; rsp_v = 1'b0;
    raddr[0] = A0; raddr[1] = A1;
    rprv[0] = 2'd1; rprv[1] = 2'd3;
    rattr[0] = 4'b0001; rattr[1] = 4'b1010;
    pte_ppn = '0; pte_f = '0;
    repeat (2) @(negedge clock);
    #1;
    cmp("rst.ctrl", 64'({req0_ready, req1_ready, resp0_valid, resp1_valid,
                         preq_v, owner, inv0, inv1}), 64'(0));
    cmp("rst.bits", 64'({p_addr, p_prv, p_attr}), 64'(0));
    reset = 1'b0;
    pte_ppn = 38'h00000ABCDE; pte_f = 8'hA5;

    tbl.push_back(mk(2'b01, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b00, 1, 0, 0, 2'b00, 2'b00, 1, 0, A0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b00, 0, 1, 0, 2'b00, 2'b01, 0, 0, 0));
    tbl.push_back(mk(2'b00, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b10, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 1, A1));
    tbl.push_back(mk(2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 1, A1));
    tbl.push_back(mk(2'b01, 0, 0, 1, 2'b00, 2'b00, 1, 1, A1));
    tbl.push_back(mk(2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 1, A1));
    tbl.push_back(mk(2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 1, A1));
    tbl.push_back(mk(2'b01, 1, 1, 0, 2'b00, 2'b00, 1, 1, A1));
    tbl.push_back(mk(2'b01, 0, 0, 1, 2'b00, 2'b00, 0, 1, 0));
    tbl.push_back(mk(2'b01, 0, 1, 0, 2'b00, 2'b10, 0, 1, 0));
    tbl.push_back(mk(2'b01, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b00, 1, 0, 0, 2'b00, 2'b00, 1, 0, A0));
    tbl.push_back(mk(2'b00, 0, 1, 0, 2'b00, 2'b01, 0, 0, 0));
    foreach (tbl[i])
      step($sformatf("vec%0d", i), tbl[i].v, tbl[i].prdy, tbl[i].rspv,
           tbl[i].inv, tbl[i].erdy, tbl[i].ersp, tbl[i].epreq,
           tbl[i].eown, tbl[i].eaddr);

    // DTLB walk first so a round-robin tie afterwards starts with the ITLB
    step("pre", 2'b10, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0);
    step("pre", 2'b00, 1, 0, 0, 2'b00, 2'b00, 1, 1, A1);
    step("pre", 2'b00, 0, 1, 0, 2'b00, 2'b10, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
`ifdef PTW_ARB_RR_EN
      g = (k == 1);
`else
      g = 1'b0;
`endif
      eg = g ? 2'b10 : 2'b01;
      step($sformatf("tie%0d", k), 2'b11, 0, 0, 0, eg, 2'b00, 0, 0, 0);
      step($sformatf("tie%0d", k), 2'b11, 1, 0, 0, 2'b00, 2'b00, 1, g,
           g ? A1 : A0);
      step($sformatf("tie%0d", k), 2'b11, 0, 1, 0, 2'b00, eg, 0, g, 0);
    end

    step("mid", 2'b01, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0);
    step("mid", 2'b00, 1, 0, 0, 2'b00, 2'b00, 1, 0, A0);
    @(negedge clock);
    reset = 1'b1; rv = 2'b00; ptw_rdy = 1'b0; rsp_v = 1'b0; inv = 1'b0;
    pte_ppn = '0; pte_f = '0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    cmp("midrst.ctrl", 64'({req0_ready, req1_ready, resp0_valid, resp1_valid,
                            preq_v, owner, inv0, inv1}), 64'(0));
    cmp("midrst.bits", 64'({p_addr, p_prv, p_attr, o_ppn[25:0], o_f}), 64'(0));
    step("midrst.spur", 2'b00, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0);
    step("midrst.spur", 2'b00, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0);

    // Random traffic against the transaction-level model
    reset = 1'b1;
    @(negedge clock);
    mst = 0; mown = 0; mlast = 0; maddr = '0; mprv = '0; mattr = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 99) == 0);
      rv = 2'($urandom_range(0, 3));
      ptw_rdy = ($urandom_range(0, 9) < 6);
      rsp_v = ($urandom_range(0, 9) < 4);
      inv = ($urandom_range(0, 9) == 0);
      for (int n = 0; n < 2; n++) begin
        raddr[n] = 27'($urandom);
        rprv[n] = 2'($urandom);
        rattr[n] = 4'($urandom);
      end
      pte_ppn = {6'($urandom), 32'($urandom)};
      pte_f = 8'($urandom);
`ifdef PTW_ARB_RR_EN
      mwin = (rv == 2'b11) ? !mlast : rv[1];
`else
      mwin = !rv[0];
`endif
      #1;
      eg = (mst == 0 && rv != 0) ? (mwin ? 2'b10 : 2'b01) : 2'b00;
      cmp("rnd.ready", 64'({req1_ready, req0_ready}), 64'(eg));
      eg = (mst == 2 && rsp_v) ? (mown ? 2'b10 : 2'b01) : 2'b00;
      cmp("rnd.resp", 64'({resp1_valid, resp0_valid}), 64'(eg));
      cmp("rnd.preq", 64'(preq_v), 64'(mst == 1));
      cmp("rnd.owner", 64'(owner), 64'(mst != 0 && mown));
      cmp("rnd.pte", 64'({o_f, o_ppn[37:12]}), 64'({pte_f, pte_ppn[37:12]}));
      cmp("rnd.inval", 64'({inv1, inv0}), 64'({inv, inv}));
      if (mst == 1)
        cmp("rnd.bits", 64'({p_addr, p_prv, p_attr}), 64'({maddr, mprv, mattr}));
      if (reset) begin
        mst = 0; mown = 0; mlast = 0;
        maddr = '0; mprv = '0; mattr = '0;
      end else if (mst == 0) begin
        if (rv != 0) begin
          mown = mwin; mlast = mwin;
          maddr = raddr[mwin]; mprv = rprv[mwin]; mattr = rattr[mwin];
          mst = 1;
        end
      end else if (mst == 1) begin
        if (ptw_rdy) mst = 2;
      end else if (rsp_v) begin
        mst = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
